// File: rtl/cic_integrator.sv
// CIC decimator integrator section: N_STAGES cascaded wrapping accumulators plus a decimation strobe.
// Optional build macro CIC_INT_SYNC_CLR_EN adds a synchronous clear input (sync_clr).
module cic_integrator #(
    parameter int WIDTH      = 32,
    parameter int IN_WIDTH   = 16,
    parameter int N_STAGES   = 4,
    parameter int RATE_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clken,
`ifdef CIC_INT_SYNC_CLR_EN
    input  logic                  sync_clr,
`endif
    input  logic [RATE_WIDTH-1:0] rate,
    input  logic [IN_WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]      data_out,
    output logic                  strobe_out
);

    logic [WIDTH-1:0]      r_stage [N_STAGES];
    logic [RATE_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]      r_data_out;
    logic                  r_strobe;
    logic [WIDTH-1:0]      w_data_ext;

    assign w_data_ext = WIDTH'($signed(data_in));

    // Sums wrap silently; the comb section relies on modular arithmetic to cancel the overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_STAGES; k++) begin
                r_stage[k] <= '0;
            end
            r_cnt      <= '0;
            r_data_out <= '0;
            r_strobe   <= 1'b0;
        end
`ifdef CIC_INT_SYNC_CLR_EN
        else if (sync_clr) begin
            for (int k = 0; k < N_STAGES; k++) begin
                r_stage[k] <= '0;
            end
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end
`endif
        else if (clken) begin
            r_stage[0] <= r_stage[0] + w_data_ext;
            for (int k = 1; k < N_STAGES; k++) begin
                r_stage[k] <= r_stage[k] + r_stage[k-1];
            end
            // rate is only looked at on reload, so a change waits for the running count to finish
            if (r_cnt == '0) begin
                r_cnt      <= rate;
                r_data_out <= r_stage[N_STAGES-1];
                r_strobe   <= 1'b1;
            end else begin
                r_cnt    <= r_cnt - RATE_WIDTH'(1);
                r_strobe <= 1'b0;
            end
        end else begin
            r_strobe <= 1'b0;
        end
    end

    assign data_out   = r_data_out;
    assign strobe_out = r_strobe;

endmodule

// File: tb/tb_cic_integrator.sv
// Self-checking bench for cic_integrator: two instances (N_STAGES=4 and N_STAGES=1) share stimulus and
// are compared against a closed-form binomial model of the integrator cascade.
module tb_cic_integrator;

    localparam int WIDTH      = 32;
    localparam int IN_WIDTH   = 16;
    localparam int RATE_WIDTH = 8;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic                  clken;
    logic                  syncClr;
    logic [RATE_WIDTH-1:0] rate;
    logic [IN_WIDTH-1:0]   dataIn;
    logic [WIDTH-1:0]      dataOutA;
    logic [WIDTH-1:0]      dataOutB;
    logic                  strobeA;
    logic                  strobeB;

    int compareCount  = 0;
    int mismatchCount = 0;

    longint           samples[$];
    int               enabledEdges;
    int               nextCapture;
    logic [WIDTH-1:0] expDataA;
    logic [WIDTH-1:0] expDataB;
    logic             expStrobe;

    always #5 clock = ~clock;

    cic_integrator #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH), .N_STAGES(4), .RATE_WIDTH(RATE_WIDTH)) dutA (
        .clock(clock),
        .reset_n(reset_n),
        .clken(clken),
`ifdef CIC_INT_SYNC_CLR_EN
        .sync_clr(syncClr),
`endif
        .rate(rate),
        .data_in(dataIn),
        .data_out(dataOutA),
        .strobe_out(strobeA)
    );

    cic_integrator #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH), .N_STAGES(1), .RATE_WIDTH(RATE_WIDTH)) dutB (
        .clock(clock),
        .reset_n(reset_n),
        .clken(clken),
`ifdef CIC_INT_SYNC_CLR_EN
        .sync_clr(syncClr),
`endif
        .rate(rate),
        .data_in(dataIn),
        .data_out(dataOutB),
        .strobe_out(strobeB)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed, input logic [WIDTH-1:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic longint binom(input longint n, input int k);
        longint c;
        if (n < 0 || n < k) return 0;
        c = 1;
        for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
        return c;
    endfunction

    // Stage k after `edges` enabled edges equals sum_j x[j] * C(edges-1-j, k), taken modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] stageValue(input int k, input int edges);
        longint acc;
        acc = 0;
        for (int j = 0; j < edges; j++) acc += samples[j] * binom(longint'(edges - 1 - j), k);
        return acc[WIDTH-1:0];
    endfunction

    task automatic modelReset();
        samples.delete();
        enabledEdges = 0;
        nextCapture  = 1;
        expDataA     = '0;
        expDataB     = '0;
        expStrobe    = 1'b0;
    endtask

    task automatic modelEdge();
`ifdef CIC_INT_SYNC_CLR_EN
        if (syncClr) begin
            samples.delete();
            enabledEdges = 0;
            nextCapture  = 1;
            expStrobe    = 1'b0;
            return;
        end
`endif
        if (clken) begin
            samples.push_back(longint'($signed(dataIn)));
            enabledEdges++;
            if (enabledEdges == nextCapture) begin
                expDataA    = stageValue(3, enabledEdges - 1);
                expDataB    = stageValue(0, enabledEdges - 1);
                expStrobe   = 1'b1;
                nextCapture = enabledEdges + int'(rate) + 1;
            end else begin
                expStrobe = 1'b0;
            end
        end else begin
            expStrobe = 1'b0;
        end
    endtask

    task automatic checkAll();
        checkOutput("dataA", dataOutA, expDataA);
        checkOutput("strobeA", {31'b0, strobeA}, {31'b0, expStrobe});
        checkOutput("dataB", dataOutB, expDataB);
        checkOutput("strobeB", {31'b0, strobeB}, {31'b0, expStrobe});
    endtask

    // Called at a falling edge: drive inputs, let one rising edge happen, check at the next falling edge.
    task automatic applyStimulus(input logic en, input logic [RATE_WIDTH-1:0] r, input logic [IN_WIDTH-1:0] d);
        clken  = en;
        rate   = r;
        dataIn = d;
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        checkAll();
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock.
    task automatic pulseReset();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("asyncResetDataA", dataOutA, '0);
        checkOutput("asyncResetDataB", dataOutB, '0);
        checkOutput("asyncResetStrobe", {31'b0, strobeA | strobeB}, '0);
        modelReset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] impulse [9];
        impulse = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd4, 32'd10, 32'd20, 32'd35};

        reset_n = 1'b0;
        clken   = 1'b0;
        syncClr = 1'b0;
        rate    = '0;
        dataIn  = '0;
        modelReset();
        repeat (3) @(negedge clock);
        checkAll();
        reset_n = 1'b1;

        $display("[TB] rate=3, constant input 1");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'd3, 16'd1);

        $display("[TB] impulse response, rate=0");
        pulseReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 8'd0, (i == 0) ? 16'd1 : 16'd0);
            checkOutput("impulseTable", dataOutA, impulse[i]);
        end

        $display("[TB] negative input wrap");
        pulseReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'd0, 16'hFFFF);

        $display("[TB] clken toggling, rate=1");
        pulseReset();
        for (int i = 0; i < 12; i++) applyStimulus(i % 2 == 0, 8'd1, 16'd2);

        $display("[TB] rate change mid-count and reset mid-count");
        pulseReset();
        applyStimulus(1'b1, 8'd3, 16'd5);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'd1, 16'd5);
        applyStimulus(1'b1, 8'd3, 16'd7);
        applyStimulus(1'b1, 8'd3, 16'd7);
        pulseReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'd2, 16'd3);

`ifdef CIC_INT_SYNC_CLR_EN
        $display("[TB] synchronous clear");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'd0, 16'd9);
        syncClr = 1'b1;
        applyStimulus(1'b1, 8'd0, 16'd9);
        syncClr = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'd1, 16'd4);
`endif

        $display("[TB] randomized run");
        pulseReset();
        begin
            logic [RATE_WIDTH-1:0] randRate;
            randRate = RATE_WIDTH'($urandom_range(0, 7));
            for (int i = 0; i < 1200; i++) begin
                if (i % 50 == 0) randRate = RATE_WIDTH'($urandom_range(0, 7));
`ifdef CIC_INT_SYNC_CLR_EN
                syncClr = ($urandom_range(0, 199) == 0);
`endif
                applyStimulus($urandom_range(0, 3) != 0, randRate, IN_WIDTH'($urandom));
            end
            syncClr = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
